// File: rtl/uart_receiver_if.sv
// uart_receiver_if: APB read-side bus shared between the UART receiver and its host.
interface uart_receiver_if;
  logic       PSEL2;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PRDATA;
  logic       PREADY;
  modport master(output PSEL2, PENABLE, PWRITE, PADDR, input PRDATA, PREADY);
  modport slave(input PSEL2, PENABLE, PWRITE, PADDR, output PRDATA, PREADY);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with APB data/status registers.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_Parity_Err flag.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic PCLK,
  input  logic PRESETn,
  uart_receiver_if.slave apb,
  input  logic i_Rx_Serial,
  output logic o_Rx_Done,
  output logic o_Rx_Valid,
  output logic o_Frame_Err,
  output logic o_Overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic o_Parity_Err
`endif
);
  typedef enum logic [2:0] {
    IDLE, START_BIT, DATA_BITS,
`ifdef UART_RX_PARITY_EN
    PARITY_BIT,
`endif
    STOP_BIT
  } state_t;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, done_q, done_d;
  logic rx_s, rd, data_rd, stat_rd, bit_end, stop_ev, par_ok, good, store, perr_bit;
  logic unused_addr;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign par_ok = par_q == ^shift_q;
  assign perr_bit = perr_q;
  assign o_Parity_Err = perr_q;
`else
  assign par_ok = 1'b1;
  assign perr_bit = 1'b0;
`endif
  assign unused_addr = ^apb.PADDR[6:1];
  assign rx_s = sync_q[1];
  assign rd = apb.PSEL2 & apb.PENABLE & ~apb.PWRITE & apb.PADDR[7] & PRESETn;
  assign data_rd = rd & ~apb.PADDR[0];
  assign stat_rd = rd & apb.PADDR[0];
  assign bit_end = cnt_q == LAST;
  assign stop_ev = (state_q == STOP_BIT) & bit_end;
  assign good = stop_ev & rx_s & par_ok;
  // A data read landing on the store cycle frees the slot, so the new byte is kept.
  assign store = good & (~valid_q | data_rd);
  assign apb.PREADY = rd;
  assign apb.PRDATA = ~rd ? 8'h00 : apb.PADDR[0] ? {4'b0, perr_bit, ovr_q, ferr_q, valid_q} : rx_data_q;
  assign o_Rx_Done = done_q;
  assign o_Rx_Valid = valid_q;
  assign o_Frame_Err = ferr_q;
  assign o_Overrun = ovr_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = (stop_ev & ~par_ok) | (perr_q & ~stat_rd);
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START_BIT;
      end
      START_BIT: if (cnt_q == HALF) begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : DATA_BITS;
      end
      DATA_BITS: if (bit_end) begin
        cnt_d = '0;
        shift_d[idx_q] = rx_s;
        idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY_BIT;
`else
        if (idx_q == 3'd7) state_d = STOP_BIT;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: if (bit_end) begin
        cnt_d = '0;
        par_d = rx_s;
        state_d = STOP_BIT;
      end
`endif
      STOP_BIT: if (bit_end) begin
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rx_data_d = store ? shift_q : rx_data_q;
    valid_d = store | (valid_q & ~data_rd);
    ferr_d = (stop_ev & ~rx_s) | (ferr_q & ~stat_rd);
    ovr_d = (good & valid_q & ~data_rd) | (ovr_q & ~stat_rd);
    done_d = store;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      rx_data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
      done_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], i_Rx_Serial};
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
      done_q <= done_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed table, hand sequences and random frames against a frame-level model.
module tb_uart_receiver;
  localparam int CPB = 16;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic rx = 1'b1;
  logic done, valid, ferr, ovr;
`ifdef UART_RX_PARITY_EN
  logic perr;
`endif
  uart_receiver_if apb();
  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb.slave), .i_Rx_Serial(rx),
    .o_Rx_Done(done), .o_Rx_Valid(valid), .o_Frame_Err(ferr), .o_Overrun(ovr)
`ifdef UART_RX_PARITY_EN
    , .o_Parity_Err(perr)
`endif
  );
  always #5 PCLK = ~PCLK;
  int tests = 0, fails = 0, done_cnt = 0;
  always @(posedge PCLK) if (done) done_cnt++;
  logic [7:0] m_data = 8'h00;
  logic m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  int m_done = 0;
  typedef struct {
    bit         send;
    logic [7:0] d;
    logic       stop;
    logic [2:0] exp_flags;
    int         rd;
    logic [7:0] exp_rd;
    int         exp_done;
  } vec_t;
  vec_t tbl[8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apb_idle();
    apb.PSEL2 = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b0;
    apb.PADDR = 8'h00;
  endtask
  task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic rdy);
    @(negedge PCLK);
    apb.PSEL2 = 1'b1;
    apb.PWRITE = 1'b0;
    apb.PADDR = addr;
    apb.PENABLE = 1'b0;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    #1;
    data = apb.PRDATA;
    rdy = apb.PREADY;
    @(negedge PCLK);
    apb_idle();
  endtask
  function automatic logic [7:0] model_read(input logic [7:0] addr);
    logic [7:0] r;
    if (addr[0]) begin
      r = {5'b0, m_ovr, m_ferr, m_valid};
      m_ovr = 1'b0;
      m_ferr = 1'b0;
    end else begin
      r = m_data;
      m_valid = 1'b0;
    end
    return r;
  endfunction
  function automatic void model_frame(input logic [7:0] d, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (!m_valid) begin
      m_data = d;
      m_valid = 1'b1;
      m_done++;
    end else m_ovr = 1'b1;
  endfunction
  function automatic logic line_val(input logic [7:0] d, input logic stop, input int c);
    int k = c / 16;
    if (k == 0) return 1'b0;
    if (k == 9) return stop;
    return d[k-1];
  endfunction
  task automatic do_read(input string name, input logic [7:0] addr);
    logic [7:0] data, exp;
    logic rdy;
    apb_read(addr, data, rdy);
    exp = model_read(addr);
    check(name, data, exp);
    check({name, "_ready"}, rdy, 1);
  endtask
  task automatic check_flags(input string name);
    check(name, {ovr, ferr, valid}, {m_ovr, m_ferr, m_valid});
    check({name, "_done"}, done_cnt, m_done);
  endtask
  // rd_at >= 0 holds a data read in the cycle right before that posedge index
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge PCLK);
      rx = line_val(d, stop, c);
      if (c == rd_at) begin
        apb.PSEL2 = 1'b1;
        apb.PENABLE = 1'b1;
        apb.PWRITE = 1'b0;
        apb.PADDR = 8'h80;
        #1;
        check("overlap_read_data", apb.PRDATA, m_data);
        check("overlap_read_ready", apb.PREADY, 1);
      end
      if (c == rd_at + 1) apb_idle();
    end
    @(negedge PCLK);
    rx = 1'b1;
    repeat (40) @(negedge PCLK);
  endtask
  initial begin
    logic [7:0] d, data;
    logic stop, rdy;
    int r;
    apb_idle();
    tbl[0] = '{1, 8'hA5, 1, 3'b001, 1, 8'hA5, 1};
    tbl[1] = '{0, 8'h00, 1, 3'b000, 0, 8'h00, 1};
    tbl[2] = '{1, 8'h3C, 0, 3'b010, 2, 8'h02, 1};
    tbl[3] = '{0, 8'h00, 1, 3'b000, 2, 8'h00, 1};
    tbl[4] = '{1, 8'h11, 1, 3'b001, 0, 8'h00, 2};
    tbl[5] = '{1, 8'h22, 1, 3'b101, 1, 8'h11, 2};
    tbl[6] = '{0, 8'h00, 1, 3'b100, 2, 8'h04, 2};
    tbl[7] = '{0, 8'h00, 1, 3'b000, 0, 8'h00, 2};
    repeat (3) @(negedge PCLK);
    check("reset_flags", {done, ovr, ferr, valid}, 0);
    check("reset_prdata", apb.PRDATA, 0);
    check("reset_ready", apb.PREADY, 0);
    PRESETn = 1'b1;
    repeat (5) @(negedge PCLK);
    foreach (tbl[i]) begin
      if (tbl[i].send) begin
        send_frame(tbl[i].d, tbl[i].stop, -1);
        model_frame(tbl[i].d, tbl[i].stop);
      end
      check($sformatf("tbl%0d_flags", i), {ovr, ferr, valid}, tbl[i].exp_flags);
      check($sformatf("tbl%0d_done", i), done_cnt, tbl[i].exp_done);
      if (tbl[i].rd != 0) begin
        apb_read(tbl[i].rd == 1 ? 8'h80 : 8'h81, data, rdy);
        void'(model_read(tbl[i].rd == 1 ? 8'h80 : 8'h81));
        check($sformatf("tbl%0d_rdata", i), data, tbl[i].exp_rd);
        check($sformatf("tbl%0d_ready", i), rdy, 1);
      end
    end
    @(negedge PCLK);
    rx = 1'b0;
    repeat (5) @(negedge PCLK);
    rx = 1'b1;
    repeat (40) @(negedge PCLK);
    check_flags("glitch");
    apb.PSEL2 = 1'b1;
    apb.PENABLE = 1'b1;
    apb.PWRITE = 1'b1;
    apb.PADDR = 8'h80;
    #1;
    check("write_ready", apb.PREADY, 0);
    check("write_prdata", apb.PRDATA, 0);
    apb.PWRITE = 1'b0;
    apb.PADDR = 8'h01;
    #1;
    check("lowaddr_ready", apb.PREADY, 0);
    check("lowaddr_prdata", apb.PRDATA, 0);
    apb_idle();
    send_frame(8'h77, 1'b1, -1);
    model_frame(8'h77, 1'b1);
    check_flags("pre_overlap");
    send_frame(8'h55, 1'b1, 10 * CPB - 6);
    m_data = 8'h55;
    m_valid = 1'b1;
    m_done++;
    check_flags("overlap");
    do_read("overlap_new_data", 8'h80);
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      send_frame(d, stop, -1);
      model_frame(d, stop);
      check_flags($sformatf("rand%0d", n));
      r = $urandom_range(0, 2);
      if (r == 1) do_read($sformatf("rand%0d_data", n), 8'h80);
      else if (r == 2) do_read($sformatf("rand%0d_status", n), 8'h81);
    end
    send_frame(8'h99, 1'b1, -1);
    model_frame(8'h99, 1'b1);
    check_flags("pre_reset");
    for (int c = 0; c < 4 * CPB + 8; c++) begin
      @(negedge PCLK);
      rx = line_val(8'h5A, 1'b1, c);
    end
    @(negedge PCLK);
    apb.PSEL2 = 1'b1;
    apb.PENABLE = 1'b1;
    apb.PADDR = 8'h81;
    PRESETn = 1'b0;
    #1;
    check("midreset_flags", {done, ovr, ferr, valid}, 0);
    check("midreset_ready", apb.PREADY, 0);
    check("midreset_prdata", apb.PRDATA, 0);
    apb_idle();
    rx = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    m_valid = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    repeat (40) @(negedge PCLK);
    send_frame(8'hC3, 1'b1, -1);
    model_frame(8'hC3, 1'b1);
    check_flags("post_reset");
    do_read("post_reset_data", 8'h80);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 87, meaning PCLK cycles per serial bit; legal range 4..65535.
REQ-002 The block SHALL have port PCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port PRESETn, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port PSEL2, input, 1, the APB select shared with the transmitter.
REQ-005 The block SHALL have port PENABLE, input, 1, the APB access phase.
REQ-006 The block SHALL have port PADDR, input, 8, the APB address; PADDR[7]=1 selects the receiver and PADDR[0] selects the register.
REQ-007 The block SHALL have port PWRITE, input, 1, the APB direction; the receiver responds only to reads (0).
REQ-008 The block SHALL have port i_Rx_Serial, input, 1, the asynchronous serial line; idle high.
REQ-009 The block SHALL have port PRDATA, output, 8, the APB read data.
REQ-010 The block SHALL have port PREADY, output, 1, the APB ready for receiver reads.
REQ-011 The block SHALL have port o_Rx_Done, output, 1, a one-cycle pulse when a byte is stored.
REQ-012 The block SHALL have ports o_Rx_Valid, o_Frame_Err and o_Overrun, output, 1 each, the status flags.

Function
REQ-013 i_Rx_Serial SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value rx_s.
REQ-014 The FSM SHALL have states IDLE, START_BIT, DATA_BITS and STOP_BIT, with a 16-bit cycle counter and a 3-bit bit index.
REQ-015 IDLE: counter=0, index=0; rx_s=0 SHALL move the FSM to START_BIT.
REQ-016 START_BIT: at counter=(CLKS_PER_BIT-1)/2, rx_s=0 SHALL clear the counter and go to DATA_BITS; rx_s=1 (glitch) SHALL return to IDLE with no flag change.
REQ-017 DATA_BITS: after CLKS_PER_BIT cycles, rx_s SHALL be sampled into shift bit [index], LSB first; after index 7 the FSM SHALL go to STOP_BIT.
REQ-018 STOP_BIT: after CLKS_PER_BIT cycles, rx_s SHALL be sampled and the FSM SHALL return to IDLE in the same cycle.
REQ-019 Stop sample=1 and o_Rx_Valid=0, or a data read in the same cycle: the byte SHALL be stored in rx_data, o_Rx_Valid SHALL be set, and o_Rx_Done SHALL pulse.
REQ-020 Stop sample=1, o_Rx_Valid=1 and no data read that cycle: the new byte SHALL be discarded, rx_data SHALL be kept, and o_Overrun SHALL be set.
REQ-021 Stop sample=0: the byte SHALL be discarded, o_Frame_Err SHALL be set, and o_Rx_Done SHALL stay 0.
REQ-022 A read SHALL be PSEL2 & PENABLE & !PWRITE & PADDR[7]; PREADY SHALL be combinational and equal 1 during a read (zero wait states), and 0 otherwise.
REQ-023 A read with PADDR[0]=0 SHALL return PRDATA=rx_data and clear o_Rx_Valid, unless a byte is stored in the same cycle, in which case o_Rx_Valid stays 1.
REQ-024 A read with PADDR[0]=1 SHALL return PRDATA={5'b0, o_Overrun, o_Frame_Err, o_Rx_Valid} and clear o_Overrun and o_Frame_Err; a same-cycle set SHALL win over the clear.
REQ-025 PRDATA SHALL be 8'h00 when no read is in progress.
REQ-026 Writes and PADDR[7]=0 accesses SHALL be ignored (PREADY=0 from this block).

Reset
REQ-027 PRESETn=0 SHALL immediately force the FSM to IDLE and clear the counter, index, shift register and rx_data, and the synchronizer SHALL be set to 1.
REQ-028 During reset, o_Rx_Done, o_Rx_Valid, o_Frame_Err, o_Overrun, PREADY and PRDATA SHALL all be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait in IDLE for the next falling edge, and remaining bits of the aborted frame may resync as a new frame.

Configuration
REQ-030 With UART_RX_PARITY_EN defined, a state PARITY_BIT SHALL sit between DATA_BITS and STOP_BIT, sampling one even-parity bit.
REQ-031 With UART_RX_PARITY_EN defined, a parity mismatch SHALL discard the byte and set status bit 3 (o_Parity_Err port, cleared like o_Frame_Err).
REQ-032 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, the o_Parity_Err port SHALL be absent, and status bit 3 SHALL read 0.

Verification (CLKS_PER_BIT=16)
REQ-033 Frame 8'hA5, valid stop bit -> o_Rx_Done pulses once, o_Rx_Valid=1; a data read returns 8'hA5 with PREADY=1 and o_Rx_Valid then reads 0.
REQ-034 A 5-cycle low glitch on an idle line -> FSM back in IDLE, and all flags and o_Rx_Done remain 0.
REQ-035 Frame 8'h3C with stop bit=0 -> o_Frame_Err=1, o_Rx_Valid=0; a status read returns 8'h02, and a second status read returns 8'h00.
REQ-036 Frames 8'h11 then 8'h22 with no read between -> o_Overrun=1; a data read returns 8'h11.
REQ-037 Frame 8'h55 with a data read asserted on the stop-sample cycle -> the read returns the old byte, then rx_data=8'h55 and o_Rx_Valid=1.
REQ-038 PRESETn pulsed low at data bit 3 of a frame -> all outputs 0 immediately; a following clean frame 8'hC3 is received correctly.
